// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, 2-FF synchronizer and 2-of-3 bit vote.
// Outputs feed the LCD reader stage's RxD_data / RxD_data_ready inputs.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_framing_err,
    output logic       RxD_busy
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_VOTE = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_WAIT_HIGH = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;

    logic          sync1_q;
    logic          sync2_q;
    logic [1:0]    hist_q;
    logic [1:0]    hist_d;
    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    idx_q;
    logic [2:0]    idx_d;
    logic [7:0]    sh_q;
    logic [7:0]    sh_d;
    logic [7:0]    data_q;
    logic [7:0]    data_d;
    logic          ready_q;
    logic          ready_d;
    logic          ferr_q;
    logic          ferr_d;
    logic          busy_q;
    logic          busy_d;
    logic          rxd_s;
    logic          vote;

    assign rxd_s = sync2_q;

    // Majority of the current and the two previous synchronized samples.
    assign vote = (rxd_s & hist_q[0])
                | (rxd_s & hist_q[1])
                | (hist_q[0] & hist_q[1]);

    assign hist_d = {hist_q[0], rxd_s};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 2'b11;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_WAIT_HIGH: begin
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!rxd_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_VOTE) begin
                    cnt_d = '0;
                    if (!vote) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    sh_d[idx_q] = vote;
                    cnt_d       = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (vote) begin
                        data_d  = sh_q;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Stop low: also covers a line break.
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT_HIGH;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WAIT_HIGH;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            sh_q    <= 8'h00;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign RxD_data        = data_q;
    assign RxD_data_ready  = ready_q;
    assign RxD_framing_err = ferr_q;
    assign RxD_busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLKS_PER_BIT=16.
// Frames are driven on negedges; strobes are sampled on negedges.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_framing_err;
    logic       RxD_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] rdy_data[$];
    int         rdy_cyc[$];
    int         err_cyc[$];

    int win_e0     = -1000;
    bit mon_busy   = 1'b0;
    int busy_drops = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk            (clk),
        .rst            (rst),
        .rxd            (rxd),
        .RxD_data       (RxD_data),
        .RxD_data_ready (RxD_data_ready),
        .RxD_framing_err(RxD_framing_err),
        .RxD_busy       (RxD_busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (RxD_data_ready) begin
            rdy_data.push_back(RxD_data);
            rdy_cyc.push_back(cyc);
        end
        if (RxD_framing_err) err_cyc.push_back(cyc);
        if (mon_busy && cyc >= win_e0 + 2 &&
            cyc <= win_e0 + 155 && !RxD_busy)
            busy_drops++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rdy_data.delete();
        rdy_cyc.delete();
        err_cyc.delete();
    endtask

    // e0 is the posedge at which the first sync flop sees the start bit.
    task automatic send_frame(input logic [7:0] b,
                              input logic stop,
                              output int e0);
        logic [9:0] f;
        f  = {stop, b, 1'b0};
        e0 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = f[i];
            if (i == 0) begin
                e0     = cyc + 1;
                win_e0 = cyc + 1;
            end
            repeat (CPB - 1) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        int e1;
        int bcnt;
        int low;
        rst = 1'b1;
        rxd = 1'b1;
        #5 rst = 1'b0;
        #50;
        check("rst_data",  RxD_data, 0);
        check("rst_ready", RxD_data_ready, 0);
        check("rst_ferr",  RxD_framing_err, 0);
        check("rst_busy",  RxD_busy, 0);
        #50 rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_busy", RxD_busy, 0);
        check("idle_strb", rdy_data.size() + err_cyc.size(), 0);
        mon_busy = 1'b1;

        clear_log();
        send_frame(8'h33, 1'b1, e0);
        repeat (20) @(negedge clk);
        check("b1_count", rdy_data.size(), 1);
        check("b1_data",  rdy_data[0], 8'h33);
        check("b1_time",  rdy_cyc[0], e0 + 156);
        check("b1_ferr",  err_cyc.size(), 0);
        check("b1_hold",  RxD_data, 8'h33);

        clear_log();
        busy_drops = 0;
        send_frame(8'h23, 1'b1, e0);
        send_frame(8'h56, 1'b1, e1);
        send_frame(8'h0D, 1'b1, e1);
        repeat (20) @(negedge clk);
        check("b2b_count", rdy_data.size(), 3);
        check("b2b_d0",    rdy_data[0], 8'h23);
        check("b2b_d1",    rdy_data[1], 8'h56);
        check("b2b_d2",    rdy_data[2], 8'h0D);
        check("b2b_t0",    rdy_cyc[0], e0 + 156);
        check("b2b_gap1",  rdy_cyc[1] - rdy_cyc[0], 160);
        check("b2b_gap2",  rdy_cyc[2] - rdy_cyc[1], 160);
        check("b2b_ferr",  err_cyc.size(), 0);
        check("b2b_busy",  busy_drops, 0);

        clear_log();
        repeat (5) @(negedge clk);
        @(negedge clk);
        rxd  = 1'b0;
        bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 4) rxd = 1'b1;
            if (RxD_busy) bcnt++;
        end
        check("gl_busy",  bcnt, 10);
        check("gl_ready", rdy_data.size(), 0);
        check("gl_ferr",  err_cyc.size(), 0);

        clear_log();
        send_frame(8'h33, 1'b1, e0);
        send_frame(8'h56, 1'b0, e1);
        repeat (40) @(negedge clk);
        check("fe_count", rdy_data.size(), 1);
        check("fe_good",  rdy_data[0], 8'h33);
        check("fe_errn",  err_cyc.size(), 1);
        check("fe_errt",  err_cyc[0], e1 + 156);
        check("fe_hold",  RxD_data, 8'h33);
        check("fe_busy1", RxD_busy, 1);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        check("fe_busy0", RxD_busy, 0);

        clear_log();
        repeat (20) @(negedge clk);
        rxd = 1'b0;
        e0  = cyc + 1;
        low = 0;
        for (int k = 1; k <= 30 * CPB; k++) begin
            @(negedge clk);
            if (k >= 3 && !RxD_busy) low++;
        end
        rxd = 1'b1;
        check("brk_errn",  err_cyc.size(), 1);
        check("brk_errt",  err_cyc[0], e0 + 156);
        check("brk_ready", rdy_data.size(), 0);
        check("brk_busy",  low, 0);
        repeat (32) @(negedge clk);
        check("brk_idle",  RxD_busy, 0);
        send_frame(8'h0D, 1'b1, e0);
        repeat (20) @(negedge clk);
        check("brk_count", rdy_data.size(), 1);
        check("brk_data",  rdy_data[0], 8'h0D);

        clear_log();
        mon_busy = 1'b0;
        repeat (10) @(negedge clk);
        fork
            send_frame(8'h56, 1'b1, e1);
            begin
                repeat (70) @(negedge clk);
                rst = 1'b0;
                #1;
                check("mr_data",  RxD_data, 0);
                check("mr_ready", RxD_data_ready, 0);
                check("mr_ferr",  RxD_framing_err, 0);
                check("mr_busy",  RxD_busy, 0);
            end
        join
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("mr_nostrb", rdy_data.size() + err_cyc.size(), 0);
        check("mr_idle",   RxD_busy, 0);
        mon_busy = 1'b1;
        send_frame(8'h0D, 1'b1, e0);
        repeat (20) @(negedge clk);
        check("mr_count", rdy_data.size(), 1);
        check("mr_rx",    rdy_data[0], 8'h0D);
        check("mr_time",  rdy_cyc[0], e0 + 156);
        check("all_busy", busy_drops, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver feeding the LCD reader stage. Recovers 8N1 asynchronous frames from the `rxd` pin, presents each valid byte on `RxD_data`, and strobes `RxD_data_ready` for exactly one clock. Its outputs connect directly to the LCD reader's `RxD_data` / `RxD_data_ready` inputs. Framing errors and line breaks are flagged separately and never produce a data strobe.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200 baud); clocks per bit period; must be ≥ 8. `H` = `CLKS_PER_BIT/2` (integer division).
- `clk`  in  1  system clock, 50 MHz nominal.
- `rst`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial line, asynchronous to `clk`, idle high.
- `RxD_data`  out  8  last correctly framed byte; holds until the next valid frame.
- `RxD_data_ready`  out  1  one-cycle strobe; `RxD_data` is valid in the same cycle.
- `RxD_framing_err`  out  1  one-cycle strobe when the stop bit is sampled low.
- `RxD_busy`  out  1  high whenever the state is not IDLE.

## Operation
- Synchronizer: 2-FF on `rxd`. Both flops reset to 1. `rxd_s` denotes the synchronized line.
- Counter: `cnt` is wide enough for `CLKS_PER_BIT-1`. Bit index `idx` is 0..7. Shift register `sh[7:0]` receives LSB first.
- Majority vote: each bit decision uses 2-of-3 of the `rxd_s` samples taken at the decision cycle and the two cycles before it.
- States:
  - **WAIT_HIGH** (reset state): go to IDLE on the first cycle `rxd_s`=1. This prevents locking onto a frame already in progress at reset release.
  - **IDLE**: on `rxd_s`=0, go to START with `cnt`=0.
  - **START**: `cnt` increments each cycle. At `cnt`=H+1, vote.
    - Vote 0: go to DATA with `cnt`=0, `idx`=0.
    - Vote 1 (glitch): go to IDLE with no strobe.
  - **DATA**: decision at `cnt`=CLKS_PER_BIT-1. The vote result is shifted into `sh` at bit `idx`, and `cnt` is set to 0. After `idx`=7, go to STOP.
  - **STOP**: decision at `cnt`=CLKS_PER_BIT-1.
    - Vote 1: load `RxD_data`←`sh`, pulse `RxD_data_ready`, go to IDLE.
    - Vote 0: pulse `RxD_framing_err`, leave `RxD_data` unchanged, go to WAIT_HIGH.
- Back-to-back frames: IDLE accepts a new start bit in the cycle immediately after STOP. No idle gap is required.
- The data strobe and the error strobe are mutually exclusive per frame. Each is high for exactly one cycle.

## Timing
- Reset values: `RxD_data`=0x00, `RxD_data_ready`=0, `RxD_framing_err`=0, `RxD_busy`=0. State = WAIT_HIGH, counters = 0.
- Reset assertion mid-frame clears everything immediately (asynchronous). The partial byte is discarded and no strobe is produced.
- Define edge E0 as the first clock edge at which the synchronizer's first flop captures `rxd`=0.
  - START is entered at E0+2.
  - The start-bit vote occurs at E0+3+H.
  - Bit i is decided at E0+3+H+(i+1)·CLKS_PER_BIT.
  - The stop bit is decided at E0+3+H+9·CLKS_PER_BIT.
  - `RxD_data_ready` (or `RxD_framing_err`) is registered and is high for the cycle following edge E0+4+H+9·CLKS_PER_BIT.
- `RxD_busy` rises with entry to START. It falls when IDLE is re-entered; after a framing error it falls on WAIT_HIGH→IDLE.
- Sampling tolerance: the middle sample lands at H+2 cycles into each bit, which tolerates ±4% baud mismatch at the default parameter.
- Glitch rejection: a low pulse shorter than H−1 cycles never leaves START.

## Test plan
Bench uses `CLKS_PER_BIT`=16 (H=8), a 20 ns clock, and `rst` pulsed low for 100 ns.

- **Single byte:** send 0x33 in 8N1 → one `RxD_data_ready` pulse with `RxD_data`=0x33 and `RxD_framing_err`=0. The pulse lands at E0+4+8+144 = E0+156.
- **Back-to-back:** send 0x23, 0x56, 0x0D with no inter-frame gap → three ready pulses spaced exactly 160 cycles apart. Values appear in order and `RxD_busy` never drops to 0 between frames.
- **Glitch rejection:** drive `rxd` low for 4 cycles, then high → `RxD_busy` pulses high for fewer than 12 cycles, with no ready strobe and no error strobe.
- **Framing error:** after a valid 0x33, send 0x56 with the stop bit low, then release high → one `RxD_framing_err` pulse, no ready strobe, and `RxD_data` stays 0x33. `RxD_busy` stays high until `rxd` returns high.
- **Break:** hold `rxd` low for 30 bit times → exactly one `RxD_framing_err` pulse, and `RxD_busy`=1 for the whole low period. A following 0x0D frame is received correctly.
- **Reset mid-frame:** assert `rst` during bit 3 of 0x56 while `rxd` keeps toggling the frame → all outputs read 0 immediately and no strobe is produced for that frame. The next full frame 0x0D is received correctly.
